// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader FSM state encoding and instruction word size.
package cpu_pkg;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } ldr_state_e;
endpackage

// File: rtl/ins_mem_loader.sv
// Streams big-endian program bytes into instruction memory one 32-bit word at a time.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte and report mismatches on err.
module ins_mem_loader
  import cpu_pkg::*;
#(
  parameter int MEM_BYTES = 128,
  parameter int BASE_ADDR = 0
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        load_start,
  input  logic [5:0]  load_len,
  input  logic        load_abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [6:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam logic [5:0] MAX_LEN = 6'(MEM_BYTES / WORD_BYTES);
  localparam logic [6:0] BASE    = 7'(BASE_ADDR);

  ldr_state_e  state_q;
  logic [1:0]  byte_cnt_q;
  logic [5:0]  word_cnt_q, len_q, len_d;
  logic [6:0]  addr_q;
  logic [31:0] data_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  xor_q;
  logic        err_q;
`endif

  assign len_d = (load_len > MAX_LEN) ? MAX_LEN : load_len;

  // Abort suppresses the strobes of the cycle it arrives in, so an aborted load never writes or completes.
  assign in_ready = (state_q == S_RECV) || (state_q == S_CHECK);
  assign wr_en    = (state_q == S_WRITE) && !load_abort;
  assign done     = (state_q == S_DONE) && !load_abort;
  assign busy     = (state_q != S_IDLE);
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
`ifdef LOADER_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 6'd0;
      len_q      <= 6'd0;
      addr_q     <= BASE;
      data_q     <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= 8'd0;
      err_q      <= 1'b0;
`endif
    end else if (load_abort && state_q != S_IDLE) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (load_start) begin
          byte_cnt_q <= 2'd0;
          word_cnt_q <= 6'd0;
          len_q      <= len_d;
          addr_q     <= BASE;
`ifdef LOADER_CHECKSUM_EN
          xor_q      <= 8'd0;
          err_q      <= 1'b0;
`endif
          state_q    <= (len_d == 6'd0) ? S_DONE : S_RECV;
        end
        S_RECV: if (in_valid) begin
          data_q     <= {data_q[23:0], in_data};
          byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          xor_q      <= xor_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) state_q <= S_WRITE;
        end
        S_WRITE: begin
          // 7-bit add wraps the address around the memory.
          addr_q     <= addr_q + 7'd4;
          word_cnt_q <= word_cnt_q + 6'd1;
          if (word_cnt_q + 6'd1 == len_q)
`ifdef LOADER_CHECKSUM_EN
            state_q <= S_CHECK;
`else
            state_q <= S_DONE;
`endif
          else
            state_q <= S_RECV;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: if (in_valid) begin
          if (in_data != xor_q) err_q <= 1'b1;
          state_q <= S_DONE;
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader: expected writes are queued as bytes are driven and checked on wr_en.
module tb_ins_mem_loader;
  logic        CLK = 1'b0, RST_n = 1'b0;
  logic        load_start = 1'b0, load_abort = 1'b0, in_valid = 1'b0;
  logic [5:0]  load_len = 6'd0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, wr_en, busy, done, err;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;

  always #5 CLK = ~CLK;

  ins_mem_loader dut (
    .CLK(CLK), .RST_n(RST_n), .load_start(load_start), .load_len(load_len),
    .load_abort(load_abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] prog [0:39];
  int          checks = 0, errors = 0;
  int          wr_cnt = 0, done_cnt = 0, busy_drops = 0, timeouts = 0;
  bit          in_load = 1'b0;
  logic [6:0]  last_addr = 7'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (in_load && busy !== 1'b1) busy_drops++;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      last_addr = wr_addr;
      if (exp_q.size() == 0) chk("wr_unexpected_addr", 32'(wr_addr), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", wr_data, e.data);
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    if (n >= 50) timeouts++;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic start_load(input logic [5:0] len);
    load_len   = len;
    load_start = 1'b1;
    @(negedge CLK);
    load_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
    if (n >= 10) timeouts++;
  endtask

  task automatic do_load(input string tag, input logic [5:0] len, input int gap);
    int         eff = (len > 6'd32) ? 32 : int'(len);
    int         w0  = wr_cnt;
    int         d0  = done_cnt;
    logic [7:0] x   = 8'd0;
    start_load(len);
    in_load = 1'b1;
    for (int i = 0; i < eff; i++) begin
      exp_q.push_back('{addr: 7'(4 * i), data: prog[i]});
      for (int j = 3; j >= 0; j--) begin
        send_byte(prog[i][8*j +: 8]);
        x ^= prog[i][8*j +: 8];
        if (gap > 0 && j == 2 && (i % 2) == 1) repeat (gap) @(negedge CLK);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (eff > 0) send_byte(x);
`endif
    wait_done();
    chk({tag, "_done_hi"}, 32'(done), 32'd1);
    in_load = 1'b0;
    @(negedge CLK);
    chk({tag, "_done_lo"}, 32'(done), 32'd0);
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(eff));
    chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    if (eff > 0) chk({tag, "_last_addr"}, 32'(last_addr), 32'(4 * (eff - 1)));
  endtask

  initial begin
    int w0, d0;
    prog[0]  = 32'h4001_000A; prog[1]  = 32'h4002_0014; prog[2]  = 32'h0022_1800;
    prog[3]  = 32'h8003_1000; prog[4]  = 32'h4004_0001; prog[5]  = 32'hC005_0002;
    prog[6]  = 32'h0000_0000; prog[7]  = 32'hFFFF_FFFF; prog[8]  = 32'h1234_5678;
    prog[9]  = 32'hA5A5_5A5A; prog[10] = 32'h0BAD_F00D; prog[11] = 32'hFC00_0000;
    for (int i = 12; i < 40; i++) prog[i] = 32'hDEAD_0000 | 32'(i);

    // Reset values
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);

    do_load("t1_single", 6'd1, 0);
    do_load("t2_twelve", 6'd12, 2);
    chk("t2_busy_held", 32'(busy_drops), 32'd0);

    // Abort midway through the third word
    w0 = wr_cnt; d0 = done_cnt;
    start_load(6'd4);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{addr: 7'(4 * i), data: prog[i]});
      for (int j = 3; j >= 0; j--) send_byte(prog[i][8*j +: 8]);
    end
    send_byte(prog[2][31:24]);
    send_byte(prog[2][23:16]);
    load_abort = 1'b1; in_valid = 1'b1; in_data = prog[2][15:8];
    @(negedge CLK);
    load_abort = 1'b0; in_valid = 1'b0;
    chk("t3_busy_after_abort", 32'(busy), 32'd0);
    chk("t3_in_ready_after_abort", 32'(in_ready), 32'd0);
    repeat (5) @(negedge CLK);
    chk("t3_writes", 32'(wr_cnt - w0), 32'd2);
    chk("t3_no_done", 32'(done_cnt - d0), 32'd0);
    do_load("t3_restart", 6'd1, 0);

    do_load("t4_clamp", 6'd40, 1);
    do_load("t5_empty", 6'd0, 0);

`ifdef LOADER_CHECKSUM_EN
    chk("t6_err_good", 32'(err), 32'd0);
    start_load(6'd1);
    exp_q.push_back('{addr: 7'd0, data: prog[0]});
    for (int j = 3; j >= 0; j--) send_byte(prog[0][8*j +: 8]);
    send_byte(8'h00);
    wait_done();
    @(negedge CLK);
    chk("t6_err_bad", 32'(err), 32'd1);
`endif

    // Reset asserted while the write strobe is high
    w0 = wr_cnt;
    start_load(6'd2);
    exp_q.push_back('{addr: 7'd0, data: prog[0]});
    for (int j = 3; j >= 0; j--) send_byte(prog[0][8*j +: 8]);
    chk("t7_wr_en_before_rst", 32'(wr_en), 32'd1);
    #2 RST_n = 1'b0;
    #1;
    chk("t7_rst_wr_en", 32'(wr_en), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t7_rst_done", 32'(done), 32'd0);
    chk("t7_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("t7_rst_wr_data", wr_data, 32'd0);
    chk("t7_rst_err", 32'(err), 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (6) @(negedge CLK);
    chk("t7_no_rewrite", 32'(wr_cnt - w0), 32'd1);
    chk("t7_idle_after", 32'(busy), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("no_timeouts", 32'(timeouts), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ins_mem_loader.md
INS_MEM_LOADER -- requirements
Module: ins_mem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128, instruction-memory size in bytes (word count = MEM_BYTES/4).
REQ-002 SHALL have parameter BASE_ADDR, default 0, byte address of first word written; must be a multiple of 4.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port load_start  input  1  one-cycle pulse; begins a load.
REQ-006 SHALL have port load_len  input  6  number of 32-bit words to load; sampled on load_start.
REQ-007 SHALL have port load_abort  input  1  terminates the load in progress.
REQ-008 SHALL have port in_valid  input  1  in_data holds a program byte.
REQ-009 SHALL have port in_data  input  8  program byte, big-endian order (MSB byte of each word first).
REQ-010 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-011 SHALL have port wr_en  output  1  instruction-memory write strobe (drives InsMemRW write side).
REQ-012 SHALL have port wr_addr  output  7  byte address of the word being written.
REQ-013 SHALL have port wr_data  output  32  assembled word; wr_data[31:24] goes to byte wr_addr.
REQ-014 SHALL have port busy  output  1  load in progress; CPU PC must be held while high.
REQ-015 SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-016 SHALL have port err  output  1  sticky checksum error (only with LOADER_CHECKSUM_EN).

Function
REQ-017 SHALL implement FSM states IDLE, RECV, WRITE, CHECK, DONE.
REQ-018 SHALL go IDLE->RECV on load_start with effective length >0; clear byte counter, word counter and err; set address to BASE_ADDR.
REQ-019 SHALL treat load_len = 0 as an empty load: IDLE->DONE, no writes.
REQ-020 SHALL clamp load_len above MEM_BYTES/4 to MEM_BYTES/4.
REQ-021 SHALL drive in_ready=1 only in RECV and CHECK; a byte is accepted only on in_valid && in_ready.
REQ-022 SHALL shift accepted bytes into the word register MSB-first; the 4th accepted byte moves RECV->WRITE.
REQ-023 SHALL in WRITE assert wr_en for exactly one cycle with in_ready=0, then add 4 to wr_addr and increment the word counter.
REQ-024 SHALL after WRITE return to RECV if words remain; otherwise go to CHECK (macro defined) or DONE.
REQ-025 SHALL wrap wr_addr modulo MEM_BYTES (7-bit arithmetic).
REQ-026 SHALL hold done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-027 SHALL keep busy=1 in all states except IDLE.
REQ-028 SHALL ignore load_start when not in IDLE.
REQ-029 SHALL on load_abort in any non-IDLE state go to IDLE next cycle: discard the partial word, no wr_en, no done; abort takes priority over a byte accepted or write scheduled in the same cycle.
REQ-030 SHALL hold wr_en=0 in all states other than WRITE.

Reset
REQ-031 SHALL on RST_n=0 immediately force state IDLE, in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, err=0, counters=0.
REQ-032 SHALL treat reset mid-load as abort; written words stay in memory, and nothing is rewritten after reset release.

Configuration
REQ-033 SHALL, with macro LOADER_CHECKSUM_EN defined, keep a running XOR of all program bytes; in CHECK, accept one trailing byte; if it differs from the XOR, set err=1 (held until next load_start or reset); then go to DONE.
REQ-034 SHALL, without LOADER_CHECKSUM_EN, omit CHECK and the XOR logic and tie err to 0.

Structure
REQ-035 SHALL place state encoding (3-bit) and the word-size constant (4 bytes) in shared package cpu_pkg.
REQ-036 SHALL be a single module; no sub-module is required.

Verification
REQ-037 SHALL cover: load_len=1, bytes 40 01 00 0A -> one wr_en, wr_addr=0, wr_data=0x4001000A, done pulse one cycle after.
REQ-038 SHALL cover: load_len=12, all 48 test-program bytes with in_valid gaps -> wr_addr 0,4,...,44; word 11=0xFC000000; busy high throughout.
REQ-039 SHALL cover: load_abort after 2 bytes of word 3 -> no 3rd write, busy=0 next cycle, no done; a following load restarts at addr 0.
REQ-040 SHALL cover: load_len=40 -> exactly 32 writes, last at wr_addr=124, no wrap write; load_len=0 -> done with no wr_en.
REQ-041 SHALL cover (with LOADER_CHECKSUM_EN): bytes 40 01 00 0A with checksum 0x4B -> err=0; with checksum 0x00 -> err=1 after done.
REQ-042 SHALL cover: RST_n low during WRITE -> wr_en falls asynchronously, all outputs at reset values.
